// File: rtl/pc_pkg.sv
// pc_pkg
// Shared definitions for the registered program-counter sequencer:
//   - pc_op_t : operation code driven on the sequencer's op port
//   - default width / depth constants used by the sequencer and its stack
// Optional feature macro used by the sequencer: PC_TRAP_EN
package pc_pkg;

   typedef enum logic [2:0] {
      HOLD   = 3'd0,
      INC    = 3'd1,
      BRANCH = 3'd2,
      JUMP   = 3'd3,
      CALL   = 3'd4,
      RET    = 3'd5
   } pc_op_t;

   localparam int DEF_ADDR_W    = 8;
   localparam int DEF_OFF_W     = 8;
   localparam int DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// return_stack
// LIFO of return addresses for CALL/RET. The stack never wraps its
// occupancy: a push while full and a pop while empty are refused.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push, pop  : request to push push_data / pop the top entry
//   push_data  : address written on an accepted push
//   top        : most recently pushed entry (undefined content when empty)
//   empty/full : registered occupancy flags derived from the stack pointer
module return_stack
   import pc_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic              empty,
   output logic              full
);

   localparam int PTR_W = $clog2(RAS_DEPTH);

   // sp counts occupied entries, so it needs one bit more than the index
   logic [PTR_W:0]      sp_q, sp_d;
   logic [ADDR_W-1:0]   entries_q [RAS_DEPTH];
   logic [ADDR_W-1:0]   entries_d [RAS_DEPTH];
   logic                empty_q, empty_d;
   logic                full_q, full_d;
   logic                push_ok;
   logic                pop_ok;
   logic [PTR_W-1:0]    wr_idx;
   logic [PTR_W-1:0]    top_idx;

   assign push_ok = push & ~full_q;
   assign pop_ok  = pop & ~empty_q;
   assign wr_idx  = sp_q[PTR_W-1:0];
   assign top_idx = wr_idx - PTR_W'(1);
   assign top     = entries_q[top_idx];
   assign empty   = empty_q;
   assign full    = full_q;

   // Next stack contents and occupancy; flags are precomputed from the
   // next pointer so they can be registered alongside it
   always_comb begin
      sp_d      = sp_q;
      entries_d = entries_q;
      if (push_ok) begin
         entries_d[wr_idx] = push_data;
         sp_d              = sp_q + (PTR_W+1)'(1);
      end else if (pop_ok) begin
         sp_d = sp_q - (PTR_W+1)'(1);
      end
      empty_d = (sp_d == '0);
      full_d  = (sp_d == (PTR_W+1)'(RAS_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q    <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         sp_q      <= sp_d;
         empty_q   <= empty_d;
         full_q    <= full_d;
         entries_q <= entries_d;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Registered program counter at the head of fetch. Supports hold,
// increment, relative branch, absolute jump, call and return, with an
// internal return-address stack and sticky overflow/underflow flags.
// Optional feature macro: PC_TRAP_EN -- when defined, a stack fault
// redirects pc to TRAP_VECTOR; otherwise pc holds on a fault.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   stall     : freezes all state, op ignored
//   op        : pc_op_t code (unused codes behave as HOLD)
//   offset    : signed branch offset relative to the current pc
//   target    : absolute destination for JUMP and CALL
//   pc        : current instruction address
//   pc_plus1  : pc + 1 modulo 2^ADDR_W
//   ras_empty : return stack empty
//   ras_full  : return stack full
//   ovf_err   : sticky, CALL seen while full
//   unf_err   : sticky, RET seen while empty
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int                ADDR_W       = DEF_ADDR_W,
   parameter int                OFF_W        = DEF_OFF_W,
   parameter int                RAS_DEPTH    = DEF_RAS_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
   parameter logic [ADDR_W-1:0] TRAP_VECTOR  = ADDR_W'(8'hF0)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic [2:0]        op,
   input  logic [OFF_W-1:0]  offset,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus1,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ovf_err,
   output logic              unf_err
);

`ifdef PC_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   pc_op_t                   op_e;
   logic [ADDR_W-1:0]        pc_q, pc_d;
   logic                     ovf_q, ovf_d;
   logic                     unf_q, unf_d;
   logic signed [OFF_W-1:0]  offset_s;
   logic [ADDR_W-1:0]        offset_ext;
   logic [ADDR_W-1:0]        fault_pc;
   logic [ADDR_W-1:0]        ras_top;
   logic                     push;
   logic                     pop;

   assign op_e       = pc_op_t'(op);
   assign offset_s   = offset;
   // Sizing cast of a signed value sign-extends to the address width
   assign offset_ext = ADDR_W'(offset_s);
   assign fault_pc   = TRAP_EN ? TRAP_VECTOR : pc_q;

   assign pc       = pc_q;
   assign pc_plus1 = pc_q + ADDR_W'(1);
   assign ovf_err  = ovf_q;
   assign unf_err  = unf_q;

   return_stack #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (pc_plus1),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full)
   );

   // Next-pc mux and stack requests. Faulting CALL/RET never touch the
   // stack; they only set their sticky flag and steer pc to fault_pc.
   always_comb begin
      pc_d  = pc_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      push  = 1'b0;
      pop   = 1'b0;
      if (!stall) begin
         case (op_e)
            INC:    pc_d = pc_plus1;
            BRANCH: pc_d = pc_q + offset_ext;
            JUMP:   pc_d = target;
            CALL: begin
               if (ras_full) begin
                  ovf_d = 1'b1;
                  pc_d  = fault_pc;
               end else begin
                  push = 1'b1;
                  pc_d = target;
               end
            end
            RET: begin
               if (ras_empty) begin
                  unf_d = 1'b1;
                  pc_d  = fault_pc;
               end else begin
                  pop  = 1'b1;
                  pc_d = ras_top;
               end
            end
            default: pc_d = pc_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= RESET_VECTOR;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

endmodule
